sample_acquire: RTL and testbench
=================================

// Module: sample_acquire
// PURPOSE
//  Upstream stage of the 4-tap moving-average filter. Paces ADC conversions from a
//  prescaled sample tick, fetches each raw unsigned sample over a req/ack handshake,
//  converts it to signed two's complement, and presents it on 'sample' with a one-cycle
//  'start' strobe. 'sample' drives the filter's 'current' input; 'start' drives its 'start' input.
// PARAMETERS
//  DIV          100  clock cycles per sample tick (1 MSPS at 100 MHz); DIV >= ACK_TIMEOUT+3
//  ADC_W        12   raw ADC word width (unsigned, offset-binary)
//  OUT_W        8    output sample width (signed); OUT_W <= ADC_W
//  ACK_TIMEOUT  15   max cycles spent in REQ waiting for adc_ack
// PORTS
//  CLK100MHZ    in   1      system clock, all logic on rising edge
//  resetn       in   1      asynchronous, active-low reset
//  enable       in   1      level; 1 = acquire continuously
//  adc_req      out  1      conversion request, held high until ack or abort
//  adc_ack      in   1      ADC data valid; sampled only while adc_req=1
//  adc_data     in   ADC_W  raw unsigned ADC word, valid when adc_ack=1
//  sample       out  OUT_W  signed converted sample (to filter 'current')
//  start        out  1      1-cycle strobe, high in the same cycle 'sample' first shows new value
//  timeout_err  out  1      sticky: an ack timeout has occurred
//  clip_count   out  16     saturating count of rail samples (CLIP_DETECT_EN only)
// BEHAVIOUR
//  - Reset (resetn=0, async): sample=0, start=0, adc_req=0, timeout_err=0, clip_count=0,
//    prescaler=0, FSM=IDLE. Reset mid-handshake drops adc_req immediately.
//  - Prescaler: counts 0..DIV-1 while enable=1, wraps; tick=1 when count==DIV-1.
//    Held at 0 while enable=0. First tick occurs DIV cycles after enable rises.
//  - FSM: IDLE -> WAIT (enable=1); WAIT -> REQ (tick); REQ -> PRESENT (adc_ack=1);
//    REQ -> WAIT (timeout); PRESENT -> WAIT (always, one cycle). Any state -> IDLE
//    when enable=0 (abort: adc_req low next cycle, no start, sample holds).
//  - adc_req=1 exactly while FSM=REQ. REQ entered the cycle after tick.
//  - On the cycle adc_ack=1 in REQ: sample <= (adc_data - 2**(ADC_W-1)) >>> (ADC_W-OUT_W),
//    computed in ADC_W+1 signed bits; result always fits OUT_W (12->8: -128..127).
//    start=1 during PRESENT (one cycle after ack edge). Latency ack->start = 1 cycle.
//  - Timeout: wait counter cleared on REQ entry; if ACK_TIMEOUT cycles elapse without ack,
//    adc_req drops, timeout_err<=1, no start, sample holds. Only resetn clears timeout_err.
//  - adc_ack outside REQ ignored. Ack on the same cycle the timeout expires: ack wins.
//  - Ticks arriving outside WAIT are dropped (cannot occur given DIV constraint).
//  - start never high on two consecutive cycles; 'sample' only changes with start.
// CONFIGURATION
//  CLIP_DETECT_EN defined: on each accepted ack where adc_data==0 or ==2**ADC_W-1,
//    clip_count increments, saturating at 16'hFFFF.
//  CLIP_DETECT_EN undefined: clip_count tied to 0, no counter logic.
// STRUCTURE
//  Package acq_pkg: FSM state enum {IDLE, WAIT, REQ, PRESENT}, ADC_MID constant,
//    clip counter width constant.
//  Sub-module tick_gen: parameterised prescaler (enable, clear, tick out).
// TESTING
//  1 Reset then enable=1, ADC acks 2 cycles after req -> first adc_req at cycle DIV+1
//    after enable, start pulses once per 100 cycles.
//  2 adc_data=12'h800 -> sample=0; 12'hFFF -> 127; 12'h000 -> -128; 12'h7F0 -> -1.
//  3 ADC never acks -> adc_req high exactly 15 cycles, timeout_err=1, no start,
//    sample unchanged; next tick issues a fresh req.
//  4 enable dropped while adc_req=1 -> adc_req=0 next cycle, no start, prescaler=0;
//    re-enable -> first req DIV+1 cycles later.
//  5 resetn pulsed low mid-REQ -> all outputs 0 asynchronously, incl. timeout_err.
//  6 CLIP_DETECT_EN: feed 3 samples of 12'hFFF and 2 of 12'h000 among others
//    -> clip_count=5; without macro -> clip_count stays 0.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and constants for the ADC sample acquisition stage.
// Used by tick_gen and sample_acquire.
package acq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ,
    PRESENT
  } acq_state_e;

  localparam int ADC_W_DEF = 12;
  localparam int CLIP_W    = 16;

  localparam logic [CLIP_W-1:0] CLIP_MAX = '1;

  function automatic int adc_mid(input int w);
    return 1 << (w - 1);
  endfunction

  localparam int ADC_MID = adc_mid(ADC_W_DEF);

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
// clear has priority and parks the count at zero.
module tick_gen
  import acq_pkg::*;
#(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == CW'(DIV - 1));
  assign tick   = en && !clear && at_top;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_top ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sample_acquire.sv
// Paces ADC conversions, fetches samples over req/ack, emits signed samples.
// Optional rail-sample counter enabled by defining CLIP_DETECT_EN.
module sample_acquire
  import acq_pkg::*;
#(
  parameter int DIV         = 100,
  parameter int ADC_W       = 12,
  parameter int OUT_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                    CLK100MHZ,
  input  logic                    resetn,
  input  logic                    enable,
  output logic                    adc_req,
  input  logic                    adc_ack,
  input  logic [ADC_W-1:0]        adc_data,
  output logic signed [OUT_W-1:0] sample,
  output logic                    start,
  output logic                    timeout_err,
  output logic [15:0]             clip_count
);

  localparam int SH = ADC_W - OUT_W;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic signed [ADC_W:0] MID =
    (ADC_W + 1)'(adc_mid(ADC_W));

  if (DIV < ACK_TIMEOUT + 3) begin : g_bad_div
    $error("DIV too small for ACK_TIMEOUT");
  end
  if (OUT_W > ADC_W) begin : g_bad_w
    $error("OUT_W must not exceed ADC_W");
  end

  acq_state_e state_q;
  acq_state_e state_d;

  logic [TW-1:0]           wait_q;
  logic [TW-1:0]           wait_d;
  logic                    req_q;
  logic                    req_d;
  logic                    start_q;
  logic                    start_d;
  logic                    terr_q;
  logic                    terr_d;
  logic signed [OUT_W-1:0] sample_q;
  logic signed [OUT_W-1:0] sample_d;

  logic tick;
  logic accept;
  logic tmo;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (CLK100MHZ),
    .rst_n (resetn),
    .en    (state_q != IDLE),
    .clear (!enable),
    .tick  (tick)
  );

  // Offset-binary to two's complement, then keep the top OUT_W bits.
  logic signed [ADC_W:0] diff;
  logic signed [ADC_W:0] conv_full;
  logic                  unused_conv;

  assign diff        = $signed({1'b0, adc_data}) - MID;
  assign conv_full   = diff >>> SH;
  assign unused_conv = ^conv_full[ADC_W:OUT_W];

  assign accept = enable && (state_q == REQ) && adc_ack;
  assign tmo    = (wait_q == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    req_d    = 1'b0;
    start_d  = 1'b0;
    terr_d   = terr_q;
    sample_d = sample_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (tick) begin
            state_d = REQ;
            req_d   = 1'b1;
            wait_d  = '0;
          end
        end
        REQ: begin
          if (adc_ack) begin
            state_d  = PRESENT;
            start_d  = 1'b1;
            sample_d = conv_full[OUT_W-1:0];
          end else if (tmo) begin
            state_d = WAIT;
            terr_d  = 1'b1;
          end else begin
            req_d  = 1'b1;
            wait_d = wait_q + TW'(1);
          end
        end
        PRESENT: begin
          state_d = WAIT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      req_q    <= 1'b0;
      start_q  <= 1'b0;
      terr_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      start_q  <= start_d;
      terr_q   <= terr_d;
      sample_q <= sample_d;
    end
  end

  assign adc_req     = req_q;
  assign start       = start_q;
  assign timeout_err = terr_q;
  assign sample      = sample_q;

`ifdef CLIP_DETECT_EN
  logic [CLIP_W-1:0] clip_q;
  logic [CLIP_W-1:0] clip_d;
  logic              is_rail;

  assign is_rail = (adc_data == '0) || (adc_data == '1);

  always_comb begin
    clip_d = clip_q;
    if (accept && is_rail && (clip_q != CLIP_MAX)) begin
      clip_d = clip_q + CLIP_W'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      clip_q <= '0;
    end else begin
      clip_q <= clip_d;
    end
  end

  assign clip_count = clip_q;
`else
  logic unused_accept;

  assign unused_accept = accept;
  assign clip_count    = '0;
`endif

endmodule

// File: tb/tb_sample_acquire.sv
// Randomized bench for sample_acquire against a timeline reference model.
// Define CLIP_DETECT_EN to also expect rail-sample counting.
module tb_sample_acquire;

  localparam int DIV   = 100;
  localparam int ADC_W = 12;
  localparam int OUT_W = 8;
  localparam int TO    = 15;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic                    enable = 1'b0;
  logic                    adc_ack = 1'b0;
  logic [ADC_W-1:0]        adc_data = '0;
  logic                    adc_req;
  logic                    start;
  logic                    timeout_err;
  logic signed [OUT_W-1:0] sample;
  logic [15:0]             clip_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sample_acquire #(
    .DIV         (DIV),
    .ADC_W       (ADC_W),
    .OUT_W       (OUT_W),
    .ACK_TIMEOUT (TO)
  ) dut (
    .CLK100MHZ   (clk),
    .resetn      (resetn),
    .enable      (enable),
    .adc_req     (adc_req),
    .adc_ack     (adc_ack),
    .adc_data    (adc_data),
    .sample      (sample),
    .start       (start),
    .timeout_err (timeout_err),
    .clip_count  (clip_count)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference timeline: edges counted since start, requests every DIV
  // edges beginning DIV+1 edges after enable is first seen.
  longint e = 0;
  longint first_req = -1;
  int cur_d = 0;
  int cur_data = 0;
  int forced_d = -1;
  int forced_data = -1;
  int exp_sample = 0;
  int exp_terr = 0;
  int exp_clip = 0;

  function automatic longint off_now();
    if (first_req < 0 || e < first_req) return -1;
    return (e - first_req) % DIV;
  endfunction

  function automatic longint k_now();
    if (first_req < 0 || e < first_req) return -1;
    return (e - first_req) / DIV;
  endfunction

  function automatic int conv(input int raw);
    int v;
    v = raw - (1 << (ADC_W - 1));
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic int pick_data();
    int sp[4] = '{'h800, 'hFFF, 'h000, 'h7F0};
    if ($urandom_range(0, 9) < 4) return sp[$urandom_range(0, 3)];
    return int'($urandom_range(0, 4095));
  endfunction

  function automatic int pick_delay();
    if ($urandom_range(0, 9) < 2) return int'($urandom_range(TO, TO + 2));
    return int'($urandom_range(0, TO - 1));
  endfunction

  task automatic step();
    longint off;
    int     exp_req;
    int     exp_start;
    int     req_len;
    @(posedge clk);
    e++;
    @(negedge clk);
    off = off_now();
    if (off == 0) begin
      cur_d    = (forced_d >= 0) ? forced_d : pick_delay();
      cur_data = (forced_data >= 0) ? forced_data : pick_data();
      forced_d    = -1;
      forced_data = -1;
    end
    req_len   = (cur_d < TO) ? cur_d + 1 : TO;
    exp_req   = (off >= 0 && off < req_len) ? 1 : 0;
    exp_start = (off >= 0 && cur_d < TO && off == cur_d + 1) ? 1 : 0;
    if (exp_start == 1) begin
      exp_sample = conv(cur_data);
`ifdef CLIP_DETECT_EN
      if ((cur_data == 0 || cur_data == 4095) && exp_clip < 'hFFFF)
        exp_clip++;
`endif
    end
    if (off >= 0 && cur_d >= TO && off == TO) exp_terr = 1;
    chk("adc_req", adc_req, exp_req);
    chk("start", start, exp_start);
    chk("sample", sample, exp_sample);
    chk("timeout_err", timeout_err, exp_terr);
    chk("clip_count", clip_count, exp_clip);
    if (off >= 0 && off == cur_d) begin
      adc_ack  = 1'b1;
      adc_data = ADC_W'(cur_data);
    end else begin
      adc_ack  = (off < 0 || off > TO + 3) &&
                 ($urandom_range(0, 19) == 0);
      adc_data = ADC_W'($urandom);
    end
  endtask

  task automatic go_to(input longint kt, input longint ot);
    int n;
    n = 0;
    while (!(k_now() == kt && off_now() == ot) && n < 4000) begin
      step();
      n++;
    end
    chk("reach_point", (n < 4000) ? 1 : 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, adc_req, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_clip"}, clip_count, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    resetn = 1'b1;
    repeat (5) step();

    enable    = 1'b1;
    first_req = e + DIV + 1;
    go_to(0, 50);
    forced_d    = TO + 1;
    go_to(1, 50);
    forced_d    = TO - 1;
    forced_data = 'hFFF;
    go_to(2, 50);
    forced_d    = 0;
    forced_data = 'h000;
    go_to(3, 50);
    forced_d    = 2;
    forced_data = 'h7F0;
    go_to(4, 50);
    forced_d    = 2;
    forced_data = 'h800;

    go_to(10, 50);
    forced_d = 12;
    go_to(11, 3);
    enable    = 1'b0;
    first_req = -1;
    repeat (6) step();
    enable    = 1'b1;
    first_req = e + DIV + 1;

    go_to(4, 50);
    forced_d = 10;
    go_to(5, 4);
    resetn = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    e++;
    @(negedge clk);
    chk_zero("in_rst");
    resetn     = 1'b1;
    adc_ack    = 1'b0;
    exp_sample = 0;
    exp_terr   = 0;
    exp_clip   = 0;
    first_req  = e + DIV + 1;

    go_to(5, 50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
